// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver that frames 11-bit words and queues bytes for a consumer.
// Build option: define PS2_PARITY_CHECK_EN to also reject frames with bad odd parity.
module ps2_rx_fifo #(
   parameter int FIFO_AW     = 3,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       nextdata_n,
   output logic [7:0] data,
   output logic       ready,
   output logic       overflow,
   output logic       frame_err
);
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

   logic [2:0]       clk_sync_q, clk_sync_d;
   logic [1:0]       dat_sync_q, dat_sync_d;
   logic             nextdata_n_q, nextdata_n_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [7:0]       byte_q, byte_d;
   logic             start_q, start_d;
`ifdef PS2_PARITY_CHECK_EN
   logic             par_q, par_d;
`endif
   logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]       mem_q [DEPTH];
   logic [7:0]       data_q, data_d;
   logic             ready_q, ready_d;
   logic             overflow_q, overflow_d;
   logic             frame_err_q, frame_err_d;

   logic fall, bit_in, stop_fall, frame_ok, timeout;
   logic empty, full, pop, push;

   always_comb begin
      clk_sync_d   = {clk_sync_q[1:0], ps2_clk};
      dat_sync_d   = {dat_sync_q[0], ps2_data};
      nextdata_n_d = nextdata_n;
      fall         = clk_sync_q[2] & ~clk_sync_q[1];
      bit_in       = dat_sync_q[1];
      stop_fall    = fall && (bit_cnt_q == 4'd10);

      bit_cnt_d = bit_cnt_q;
      to_cnt_d  = to_cnt_q;
      byte_d    = byte_q;
      start_d   = start_q;
      timeout   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_d     = par_q;
      frame_ok  = ~start_q & bit_in & (^{byte_q, par_q});
`else
      frame_ok  = ~start_q & bit_in;
`endif

      if (fall) begin
         if (bit_cnt_q == 4'd0) start_d = bit_in;
         if ((bit_cnt_q >= 4'd1) && (bit_cnt_q <= 4'd8)) byte_d = {bit_in, byte_q[7:1]};
`ifdef PS2_PARITY_CHECK_EN
         if (bit_cnt_q == 4'd9) par_d = bit_in;
`endif
         bit_cnt_d = (bit_cnt_q == 4'd10) ? 4'd0 : bit_cnt_q + 4'd1;
         to_cnt_d  = '0;
      end else if (bit_cnt_q == 4'd0) begin
         to_cnt_d = '0;
      end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
         // A stalled device would otherwise leave us misaligned for every later frame.
         timeout   = 1'b1;
         bit_cnt_d = 4'd0;
         to_cnt_d  = '0;
      end else begin
         to_cnt_d = to_cnt_q + TO_W'(1);
      end

      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
              (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
      pop   = nextdata_n_q & ~nextdata_n & ready_q & ~empty;
      push  = stop_fall & frame_ok & (~full | pop);

      wr_ptr_d    = wr_ptr_q + {{FIFO_AW{1'b0}}, push};
      rd_ptr_d    = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
      overflow_d  = overflow_q | (stop_fall & frame_ok & full & ~pop);
      frame_err_d = (stop_fall & ~frame_ok) | timeout;
      ready_d     = ~empty;
      data_d      = empty ? data_q : mem_q[rd_ptr_q[FIFO_AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         clk_sync_q   <= 3'b111;
         dat_sync_q   <= 2'b11;
         nextdata_n_q <= 1'b1;
         bit_cnt_q    <= '0;
         to_cnt_q     <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         data_q       <= '0;
         ready_q      <= 1'b0;
         overflow_q   <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         clk_sync_q   <= clk_sync_d;
         dat_sync_q   <= dat_sync_d;
         nextdata_n_q <= nextdata_n_d;
         bit_cnt_q    <= bit_cnt_d;
         to_cnt_q     <= to_cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         data_q       <= data_d;
         ready_q      <= ready_d;
         overflow_q   <= overflow_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // Frame assembly and storage carry no reset; control state decides what is valid.
   always_ff @(posedge clk) begin
      byte_q  <= byte_d;
      start_q <= start_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q   <= par_d;
`endif
      if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= byte_q;
   end

   assign data      = data_q;
   assign ready     = ready_q;
   assign overflow  = overflow_q;
   assign frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: drives PS/2 frames and consumer pops into ps2_rx_fifo, compared to a queue model.
module tb_ps2_rx_fifo;
   localparam int TO = 600;
   localparam int H  = 8;

   logic       clk = 1'b0;
   logic       clr, ps2_clk, ps2_data, nextdata_n;
   logic [7:0] data;
   logic       ready, overflow, frame_err;

   int         tests_run = 0;
   int         tests_failed = 0;
   int         err_seen = 0;
   int         err_exp = 0;
   logic [7:0] model_q[$];
   logic       model_ovf = 1'b0;

   always #5 clk = ~clk;

   ps2_rx_fifo #(.FIFO_AW(3), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .clr(clr), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .nextdata_n(nextdata_n), .data(data), .ready(ready),
      .overflow(overflow), .frame_err(frame_err)
   );

   always @(posedge clk) if (frame_err === 1'b1) err_seen <= err_seen + 1;

   function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic par_flip,
                                           input logic start, input logic stop);
      logic par;
      par = ~(^b) ^ par_flip;
      return {stop, par, b, start};
   endfunction

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); ps2_data = bits[i];
         repeat (H) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (H) @(negedge clk);
         ps2_clk = 1'b1;
      end
   endtask

   task automatic model_frame(input logic par_flip, input logic start, input logic stop,
                              input logic [7:0] b);
      bit ok;
      ok = (start == 1'b0) && (stop == 1'b1);
`ifdef PS2_PARITY_CHECK_EN
      if (par_flip) ok = 0;
`endif
      if (!ok) err_exp++;
      else if (model_q.size() == 8) model_ovf = 1'b1;
      else model_q.push_back(b);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par_flip,
                             input logic start, input logic stop);
      send_bits(mk_frame(b, par_flip, start, stop), 11);
      model_frame(par_flip, start, stop, b);
      repeat (6) @(negedge clk);
   endtask

   task automatic do_pop(input int hold);
      @(negedge clk); nextdata_n = 1'b0;
      repeat (hold) @(negedge clk);
      nextdata_n = 1'b1;
      repeat (3) @(negedge clk);
      if (model_q.size() > 0) void'(model_q.pop_front());
   endtask

   task automatic do_clr();
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      model_q.delete();
      model_ovf = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      clr = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
      repeat (3) @(negedge clk);
      tests_run++; if (data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h exp 00", data); end
      tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b exp 0", ready); end
      tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b exp 0", overflow); end
      tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err: got %b exp 0", frame_err); end
      clr = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_first_frame();
      int e0;
      e0 = err_seen;
      send_bits(mk_frame(8'h1C, 1'b0, 1'b0, 1'b1), 10);
      @(negedge clk); ps2_data = 1'b1;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      // two synchronizer edges to detect the fall, then push, then ready
      repeat (3) @(posedge clk); #1;
      tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("FAIL latency_early: got ready %b exp 0", ready); end
      @(posedge clk); #1;
      tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("FAIL latency_ready: got ready %b exp 1", ready); end
      tests_run++; if (data !== 8'h1C) begin tests_failed++; $display("FAIL first_data: got %h exp 1c", data); end
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
      model_q.push_back(8'h1C);
      tests_run++; if (err_seen !== e0) begin tests_failed++; $display("FAIL first_err: got %0d exp %0d", err_seen, e0); end
      do_pop(1);
      tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("FAIL first_pop_ready: got %b exp 0", ready); end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 9; i++) begin
         send_frame(8'(i), 1'b0, 1'b0, 1'b1);
         if (i >= 8) begin
            tests_run++;
            if (overflow !== model_ovf) begin
               tests_failed++; $display("FAIL ovf_after_%0d: got %b exp %b", i, overflow, model_ovf);
            end
         end
      end
      for (int i = 1; i <= 8; i++) begin
         tests_run++;
         if (ready !== 1'b1 || data !== 8'(i)) begin
            tests_failed++; $display("FAIL ovf_pop_%0d: got ready %b data %h exp 1 %h", i, ready, data, 8'(i));
         end
         do_pop(2);
      end
      tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("FAIL ovf_drained: got %b exp 0", ready); end
      tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b exp 1", overflow); end
   endtask

   task automatic test_parity();
      do_clr();
      send_frame(8'h1C, 1'b1, 1'b0, 1'b1);
      tests_run++; if (err_seen !== err_exp) begin tests_failed++; $display("FAIL parity_err: got %0d exp %0d", err_seen, err_exp); end
      tests_run++; if (ready !== (model_q.size() > 0)) begin tests_failed++; $display("FAIL parity_ready: got %b exp %0d", ready, model_q.size()); end
      if (model_q.size() > 0) begin
         tests_run++; if (data !== 8'h1C) begin tests_failed++; $display("FAIL parity_data: got %h exp 1c", data); end
      end
      do_pop(1);
      send_frame(8'h3E, 1'b0, 1'b0, 1'b0);
      tests_run++; if (err_seen !== err_exp || ready !== 1'b0) begin
         tests_failed++; $display("FAIL bad_stop: got err %0d ready %b exp %0d 0", err_seen, ready, err_exp);
      end
   endtask

   task automatic test_timeout();
      send_bits(mk_frame(8'h33, 1'b0, 1'b0, 1'b1), 5);
      repeat (TO + 10) @(negedge clk);
      err_exp++;
      tests_run++; if (err_seen !== err_exp) begin tests_failed++; $display("FAIL timeout_err: got %0d exp %0d", err_seen, err_exp); end
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
      tests_run++; if (ready !== 1'b1 || data !== 8'h5A) begin
         tests_failed++; $display("FAIL timeout_data: got ready %b data %h exp 1 5a", ready, data);
      end
      tests_run++; if (err_seen !== err_exp) begin tests_failed++; $display("FAIL timeout_one_pulse: got %0d exp %0d", err_seen, err_exp); end
      do_pop(1);
      tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("FAIL timeout_only_one: got %b exp 0", ready); end
   endtask

   task automatic test_hold_pop();
      send_frame(8'h12, 1'b0, 1'b0, 1'b1);
      send_frame(8'hF0, 1'b0, 1'b0, 1'b1);
      tests_run++; if (data !== 8'h12) begin tests_failed++; $display("FAIL hold_head: got %h exp 12", data); end
      @(negedge clk); nextdata_n = 1'b0;
      repeat (1000) @(negedge clk);
      tests_run++; if (ready !== 1'b1 || data !== 8'hF0) begin
         tests_failed++; $display("FAIL hold_one_pop: got ready %b data %h exp 1 f0", ready, data);
      end
      nextdata_n = 1'b1;
      void'(model_q.pop_front());
      repeat (3) @(negedge clk);
      do_pop(1);
      tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("FAIL hold_drain: got %b exp 0", ready); end
   endtask

   task automatic test_clr_mid();
      for (int i = 0; i < 9; i++) send_frame(8'hA0 + 8'(i), 1'b0, 1'b0, 1'b1);
      send_bits(mk_frame(8'h77, 1'b0, 1'b0, 1'b1), 7);
      do_clr();
      tests_run++; if (ready !== 1'b0 || overflow !== 1'b0) begin
         tests_failed++; $display("FAIL clr_mid_state: got ready %b ovf %b exp 0 0", ready, overflow);
      end
      send_frame(8'h29, 1'b0, 1'b0, 1'b1);
      tests_run++; if (ready !== 1'b1 || data !== 8'h29 || overflow !== 1'b0) begin
         tests_failed++; $display("FAIL clr_mid_data: got ready %b data %h ovf %b exp 1 29 0", ready, data, overflow);
      end
      do_pop(1);
      tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("FAIL clr_mid_only: got %b exp 0", ready); end
   endtask

   task automatic test_random();
      int kind;
      logic [7:0] b;
      do_clr();
      for (int i = 0; i < 40; i++) begin
         kind = int'($urandom_range(0, 6));
         b = 8'($urandom);
         case (kind)
            0, 1, 2: send_frame(b, 1'b0, 1'b0, 1'b1);
            3:       send_frame(b, 1'b1, 1'b0, 1'b1);
            4:       send_frame(b, 1'b0, 1'b1, 1'b1);
            5:       send_frame(b, 1'b0, 1'b0, 1'b0);
            default: do_pop(int'($urandom_range(1, 6)));
         endcase
         tests_run++;
         if (ready !== (model_q.size() > 0) || overflow !== model_ovf || err_seen !== err_exp ||
             (model_q.size() > 0 && data !== model_q[0])) begin
            tests_failed++;
            $display("FAIL random_%0d: got ready %b data %h ovf %b err %0d exp size %0d ovf %b err %0d",
                     i, ready, data, overflow, err_seen, model_q.size(), model_ovf, err_exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_overflow();
      test_parity();
      test_timeout();
      test_hold_pop();
      test_clr_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
